rmw_sequencer: RTL and testbench

// Sequences the 6502 read-modify-write memory instructions (ASL/LSR/ROL/ROR/INC/DEC on memory) around the shared ALU.
// - Issues the operand read and the optional dummy write of the original value.
// - Drives ALU select/operands, writes back the result and hands the new status to the CPU core.
// - Sits between the CPU decode/control unit and the memory bus / ALU instance.

---
 rtl/rmw_sequencer.sv | 137 +++++++++++++
 tb/tb_rmw_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer for 6502 memory shift/rotate/INC/DEC around the shared ALU.
// Optional MODIFY-cycle dummy write of the original value: define RMW_DUMMY_WRITE_EN.
module rmw_sequencer #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        status_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        alu_sel,
  output logic [7:0]        alu_in1,
  output logic [7:0]        alu_in2,
  output logic [7:0]        alu_status,
  input  logic [7:0]        alu_out,
  input  logic [7:0]        alu_next_status,
  output logic [7:0]        status_out,
  output logic              status_we
);

  localparam logic [7:0] DO_OP_SRC2   = 8'h00;
  localparam logic [7:0] DO_OP_ASL    = 8'h01;
  localparam logic [7:0] DO_OP_LSR    = 8'h02;
  localparam logic [7:0] DO_OP_ROL    = 8'h03;
  localparam logic [7:0] DO_OP_ROR    = 8'h04;
  localparam logic [7:0] DO_OP_ADD_NZ = 8'h05;
  localparam logic [7:0] DO_OP_SUB_NZ = 8'h06;

  typedef enum logic [1:0] {StIdle, StRead, StModify, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        status_q;
  logic [7:0]        operand_q;
  logic [7:0]        sel_q;
  logic [7:0]        in2_q;
  logic [7:0]        sel_map;
  logic              op_legal;
  logic              accept;

  assign op_legal = (op <= 3'd5);
  assign accept   = (state_q == StIdle) && start && op_legal;

  always_comb begin
    sel_map = DO_OP_SRC2;
    case (op)
      3'd0:    sel_map = DO_OP_ASL;
      3'd1:    sel_map = DO_OP_LSR;
      3'd2:    sel_map = DO_OP_ROL;
      3'd3:    sel_map = DO_OP_ROR;
      3'd4:    sel_map = DO_OP_ADD_NZ;
      3'd5:    sel_map = DO_OP_SUB_NZ;
      default: sel_map = DO_OP_SRC2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      status_q  <= '0;
      operand_q <= '0;
      sel_q     <= DO_OP_SRC2;
      in2_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr;
        status_q <= status_in;
        sel_q    <= sel_map;
        in2_q    <= (op == 3'd4 || op == 3'd5) ? 8'h01 : 8'h00;
      end
      if (state_q == StModify) operand_q <= mem_rdata;
      // ALU returns to pass-through once the result has been written back
      if (state_q == StWrite) begin
        sel_q <= DO_OP_SRC2;
        in2_q <= '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != StIdle);
    done       = 1'b0;
    err        = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = '0;
    status_out = '0;
    status_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_legal) state_d = StRead;
          else          err     = 1'b1;
        end
      end
      StRead: begin
        mem_rd  = 1'b1;
        state_d = StModify;
      end
      StModify: begin
`ifdef RMW_DUMMY_WRITE_EN
        mem_wr    = 1'b1;
        mem_wdata = mem_rdata;
`endif
        state_d = StWrite;
      end
      StWrite: begin
        mem_wr     = 1'b1;
        mem_wdata  = alu_out;
        status_out = alu_next_status;
        status_we  = 1'b1;
        done       = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr   = busy ? addr_q : '0;
  assign alu_sel    = sel_q;
  assign alu_in1    = operand_q;
  assign alu_in2    = in2_q;
  assign alu_status = status_q;

endmodule

// File: tb/tb_rmw_sequencer.sv
// Self-checking bench for rmw_sequencer: directed vector table, corner sequences, random ops
// checked against an arithmetic reference model; includes a bus memory and ALU stand-in.
module tb_rmw_sequencer;

  localparam logic [7:0] OP_SRC2 = 8'h00;
  localparam logic [7:0] OP_ASL  = 8'h01;
  localparam logic [7:0] OP_LSR  = 8'h02;
  localparam logic [7:0] OP_ROL  = 8'h03;
  localparam logic [7:0] OP_ROR  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] addr = '0;
  logic [7:0]  status_in = '0;
  logic        busy, done, err, mem_rd, mem_wr, status_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, alu_sel, alu_in1, alu_in2, alu_status;
  logic [7:0]  alu_out, alu_next_status, status_out;

  logic [7:0]  mem [0:65535];
  int          n_total = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          we_cnt = 0;

  always #5 clk = ~clk;

  rmw_sequencer #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .addr(addr), .status_in(status_in),
    .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_sel(alu_sel),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_status(alu_status), .alu_out(alu_out),
    .alu_next_status(alu_next_status), .status_out(status_out), .status_we(status_we)
  );

  // Synchronous-read bus memory: data appears the cycle after mem_rd.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  // ALU stand-in.
  always_comb begin
    alu_out         = alu_in2;
    alu_next_status = alu_status;
    case (alu_sel)
      OP_SRC2: alu_out = alu_in2;
      OP_ASL: begin alu_out = {alu_in1[6:0], 1'b0}; alu_next_status[0] = alu_in1[7]; end
      OP_LSR: begin alu_out = {1'b0, alu_in1[7:1]}; alu_next_status[0] = alu_in1[0]; end
      OP_ROL: begin
        alu_out = {alu_in1[6:0], alu_status[0]}; alu_next_status[0] = alu_in1[7];
      end
      OP_ROR: begin
        alu_out = {alu_status[0], alu_in1[7:1]}; alu_next_status[0] = alu_in1[0];
      end
      OP_ADD: alu_out = alu_in1 + alu_in2;
      OP_SUB: alu_out = alu_in1 - alu_in2;
      default: alu_out = 8'hEE;
    endcase
    if (alu_sel != OP_SRC2) begin
      alu_next_status[7] = alu_out[7];
      alu_next_status[1] = (alu_out == 8'h00);
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (status_we) we_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: 6502 RMW semantics from plain arithmetic.
  task automatic ref_rmw(input int o, input int v, input int p, output logic [7:0] w,
                         output logic [7:0] s);
    int r, c;
    c = p % 2;
    case (o)
      0: begin r = (v * 2) % 256;           c = v / 128; end
      1: begin r = v / 2;                   c = v % 2;   end
      2: begin r = (v * 2 + p % 2) % 256;   c = v / 128; end
      3: begin r = v / 2 + (p % 2) * 128;   c = v % 2;   end
      4: r = (v + 1) % 256;
      default: r = (v + 255) % 256;
    endcase
    w = 8'(r);
    s = 8'(p);
    s[7] = (r >= 128);
    s[1] = (r == 0);
    s[0] = c[0];
  endtask

  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [7:0] v,
                        input logic [7:0] p, input logic [7:0] ew, input logic [7:0] es,
                        input bit hold);
    mem[a] = v;
    @(posedge clk); #1;
    start = 1'b1; op = o; addr = a; status_in = p;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    @(posedge clk); #1;
    // Scramble live inputs: result must depend only on the latched values.
    status_in = ~p; addr = ~a;
    start = hold; op = 3'd7;
    @(negedge clk);
    chk("read_busy", busy, 1);
    chk("read_rd", mem_rd, 1);
    chk("read_wr", mem_wr, 0);
    chk("read_addr", mem_addr, a);
    chk("read_err", err, 0);
    @(posedge clk); #1;
    op = o;
    @(negedge clk);
    chk("mod_rd", mem_rd, 0);
    chk("mod_addr", mem_addr, a);
    chk("mod_done", done, 0);
    chk("mod_err", err, 0);
`ifdef RMW_DUMMY_WRITE_EN
    chk("mod_dummy_wr", mem_wr, 1);
    chk("mod_dummy_data", mem_wdata, v);
`else
    chk("mod_no_wr", mem_wr, 0);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("wr_strobe", mem_wr, 1);
    chk("wr_rd", mem_rd, 0);
    chk("wr_addr", mem_addr, a);
    chk("wr_data", mem_wdata, ew);
    chk("wr_done", done, 1);
    chk("wr_status_we", status_we, 1);
    chk("wr_status", status_out, es);
    @(posedge clk); #1;
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_addr", mem_addr, 0);
    chk("end_sel", alu_sel, OP_SRC2);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [7:0]  v, p, w, s;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [7:0] ew, es;
    int d0, w0;
    tbl[0] = '{op: 3'd0, a: 16'h0010, v: 8'h80, p: 8'h00, w: 8'h00, s: 8'h03};
    tbl[1] = '{op: 3'd3, a: 16'h0200, v: 8'h01, p: 8'h01, w: 8'h80, s: 8'h81};
    tbl[2] = '{op: 3'd4, a: 16'h0300, v: 8'hFF, p: 8'h41, w: 8'h00, s: 8'h43};
    tbl[3] = '{op: 3'd5, a: 16'h0301, v: 8'h00, p: 8'h00, w: 8'hFF, s: 8'h80};
    tbl[4] = '{op: 3'd1, a: 16'h0400, v: 8'h81, p: 8'h80, w: 8'h40, s: 8'h01};
    tbl[5] = '{op: 3'd2, a: 16'h0500, v: 8'h40, p: 8'h01, w: 8'h81, s: 8'h80};
    tbl[6] = '{op: 3'd5, a: 16'h0302, v: 8'h01, p: 8'h82, w: 8'h00, s: 8'h02};

    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_sel", alu_sel, OP_SRC2);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);
    chk("rst_status_we", status_we, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 7; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].v, tbl[i].p, tbl[i].w, tbl[i].s, 1'b0);

    // Illegal ops: single-cycle err, no state change, no bus activity.
    for (int k = 6; k < 8; k++) begin
      @(posedge clk); #1;
      start = 1'b1; op = 3'(k); addr = 16'h1234;
      @(negedge clk);
      chk("ill_err", err, 1);
      chk("ill_busy", busy, 0);
      chk("ill_bus", {mem_rd, mem_wr}, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("ill_err_pulse", err, 0);
      chk("ill_busy_after", busy, 0);
    end

    // Start held high through READ/MODIFY: one operation, one done.
    d0 = done_cnt;
    run_op(3'd4, 16'h0600, 8'h7F, 8'h00, 8'h80, 8'h80, 1'b1);
    repeat (4) @(posedge clk);
    chk("hold_one_done", done_cnt - d0, 1);

    // Reset during MODIFY aborts the operation.
    d0 = done_cnt; w0 = we_cnt;
    mem[16'h0700] = 8'h12;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; addr = 16'h0700; status_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_modify", busy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_wr", mem_wr, 0);
    chk("abort_status_we", status_we, 0);
    chk("abort_addr", mem_addr, 0);
    repeat (4) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_we", we_cnt - w0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0]  ro;
      logic [15:0] ra;
      logic [7:0]  rv, rp;
      ro = 3'($urandom_range(0, 5));
      ra = 16'($urandom);
      rv = 8'($urandom);
      rp = 8'($urandom);
      ref_rmw(int'(ro), int'(rv), int'(rp), ew, es);
      run_op(ro, ra, rv, rp, ew, es, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
